// File: rtl/first_edge_bram_arbiter.sv
// Round-robin arbiter sharing one first-edge BRAM read port among CORE_NUM cores.
// Optional performance counters are enabled with `define FIRST_EDGE_ARB_PERF_EN.
module first_edge_bram_arbiter #(
    parameter int FIRST_EDGE_BRAM_AWIDTH = 11,
    parameter int FIRST_EDGE_BRAM_DWIDTH = 32,
    parameter int CORE_NUM               = 16,
    parameter int CORE_NUM_WIDTH         = 4,
    parameter int RD_LATENCY             = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [CORE_NUM*FIRST_EDGE_BRAM_AWIDTH-1:0]  req_addr,
    input  logic [CORE_NUM-1:0]                         req_valid,
    output logic [CORE_NUM-1:0]                         req_ready,
    output logic [CORE_NUM*FIRST_EDGE_BRAM_DWIDTH-1:0]  rsp_data,
    output logic [CORE_NUM-1:0]                         rsp_valid,
    input  logic [CORE_NUM-1:0]                         rsp_ready,
    output logic                                        bram_en,
    output logic [FIRST_EDGE_BRAM_AWIDTH-1:0]           bram_addr,
    input  logic [FIRST_EDGE_BRAM_DWIDTH-1:0]           bram_dout
`ifdef FIRST_EDGE_ARB_PERF_EN
    ,
    output logic [31:0]                                 perf_grant_cnt,
    output logic [31:0]                                 perf_conflict_cnt
`endif
);

    logic [CORE_NUM-1:0]                   busy;
    logic [CORE_NUM-1:0]                   eligible;
    logic [CORE_NUM-1:0]                   grant_oh;
    logic [CORE_NUM-1:0]                   consume;
    logic [CORE_NUM-1:0]                   capture_oh;
    logic [CORE_NUM_WIDTH-1:0]             rr_ptr;
    logic [CORE_NUM_WIDTH-1:0]             grant_idx;
    logic [CORE_NUM_WIDTH-1:0]             scan_idx;
    logic [CORE_NUM_WIDTH-1:0]             bram_tag;
    logic                                  grant_vld;
    logic [FIRST_EDGE_BRAM_AWIDTH-1:0]     grant_addr;
    logic [RD_LATENCY:0]                   pipe_vld;
    logic [RD_LATENCY:0][CORE_NUM_WIDTH-1:0] pipe_tag;

    assign eligible = req_valid & ~busy;
    assign consume  = rsp_valid & rsp_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned off = 0; off < CORE_NUM; off++) begin
            scan_idx = CORE_NUM_WIDTH'((32'(rr_ptr) + off) % CORE_NUM);
            if (!grant_vld && eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        capture_oh = '0;
        if (pipe_vld[RD_LATENCY]) capture_oh[pipe_tag[RD_LATENCY]] = 1'b1;
    end

    assign req_ready  = grant_oh;
    assign grant_addr = req_addr[grant_idx*FIRST_EDGE_BRAM_AWIDTH +: FIRST_EDGE_BRAM_AWIDTH];

    // bram_tag travels with bram_en; pipeline stage 0 loads when the BRAM samples the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            rr_ptr    <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            bram_tag  <= '0;
            pipe_vld  <= '0;
            pipe_tag  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            busy    <= (busy | grant_oh) & ~consume;
            bram_en <= grant_vld;
            if (grant_vld) begin
                rr_ptr    <= (grant_idx == CORE_NUM_WIDTH'(CORE_NUM - 1)) ? '0 : grant_idx + 1'b1;
                bram_addr <= grant_addr;
                bram_tag  <= grant_idx;
            end
            pipe_vld  <= {pipe_vld[RD_LATENCY-1:0], bram_en};
            pipe_tag  <= {pipe_tag[RD_LATENCY-1:0], bram_tag};
            rsp_valid <= (rsp_valid & ~consume) | capture_oh;
            if (pipe_vld[RD_LATENCY])
                rsp_data[pipe_tag[RD_LATENCY]*FIRST_EDGE_BRAM_DWIDTH +: FIRST_EDGE_BRAM_DWIDTH] <= bram_dout;
        end
    end

`ifdef FIRST_EDGE_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grant_cnt    <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (grant_vld && perf_grant_cnt != '1)
                perf_grant_cnt <= perf_grant_cnt + 32'd1;
            // Two or more bits set exactly when clearing the lowest set bit leaves something.
            if (((eligible & (eligible - 1'b1)) != '0) && perf_conflict_cnt != '1)
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_first_edge_bram_arbiter.sv
// Self-checking bench for first_edge_bram_arbiter with a cycle-level reference model.
module tb_first_edge_bram_arbiter;
    localparam int N  = 16;
    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] rsp_data;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready = '1;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;
    logic [DW-1:0] q0 = '0, q1 = '0;
`ifdef FIRST_EDGE_ARB_PERF_EN
    logic [31:0]   pg, pc;
`endif

    first_edge_bram_arbiter #(
        .FIRST_EDGE_BRAM_AWIDTH(AW), .FIRST_EDGE_BRAM_DWIDTH(DW),
        .CORE_NUM(N), .CORE_NUM_WIDTH(4), .RD_LATENCY(2)
    ) dut (
`ifdef FIRST_EDGE_ARB_PERF_EN
        .perf_grant_cnt(pg), .perf_conflict_cnt(pc),
`endif
        .clk(clk), .rst(rst), .req_addr(req_addr), .req_valid(req_valid),
        .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    // BRAM model: enable sampled at an edge, dout valid two cycles later, content = addr+3.
    always @(posedge clk) begin
        q0        <= bram_en ? DW'(bram_addr) + 32'd3 : 32'hDEAD_BEEF;
        q1        <= q0;
        bram_dout <= q1;
    end

    int          checks = 0;
    int          errors = 0;
    int          e = 0;
    int          m_ptr;
    bit          m_busy[N];
    bit          m_have[N];
    int          m_pend[N];
    logic [DW-1:0] m_data[N];
    logic [DW-1:0] m_last[N];
    bit          m_en;
    logic [AW-1:0] m_addr;
    bit          want[N];
    bit          sticky[N];
    logic [AW-1:0] waddr[N];
    logic [N-1:0] obs_rdy;
    bit          obs_en;

    task automatic model_reset();
        m_ptr = 0; m_en = 0; m_addr = '0;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_have[i] = 0; m_pend[i] = 0;
            m_data[i] = '0; m_last[i] = '0;
        end
    endtask

    task automatic clear_wants();
        for (int i = 0; i < N; i++) begin want[i] = 0; sticky[i] = 0; end
    endtask

    // One clock: drive, compare against the model before the edge, advance the model.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy, exp_vld;
        logic [N*DW-1:0] exp_data;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = want[i];
            req_addr[i*AW +: AW] = want[i] ? waddr[i] : AW'($urandom);
        end
        @(negedge clk);
        g = -1;
        for (int off = 0; off < N; off++)
            if (g < 0 && want[(m_ptr + off) % N] && !m_busy[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_vld[i] = m_have[i] && e >= m_pend[i];
            exp_data[i*DW +: DW] = exp_vld[i] ? m_data[i] : m_last[i];
        end
        obs_rdy = req_ready;
        obs_en  = bram_en;
        checks += 4;
        if (req_ready !== exp_rdy) begin
            errors++; $display("FAIL req_ready @%0d: got %h expected %h", e, req_ready, exp_rdy);
        end
        if (rsp_valid !== exp_vld) begin
            errors++; $display("FAIL rsp_valid @%0d: got %h expected %h", e, rsp_valid, exp_vld);
        end
        if (rsp_data !== exp_data) begin
            errors++; $display("FAIL rsp_data @%0d: got %h expected %h", e, rsp_data, exp_data);
        end
        if ({bram_en, bram_addr} !== {m_en, m_addr}) begin
            errors++; $display("FAIL bram_port @%0d: got en=%b addr=%h expected en=%b addr=%h",
                               e, bram_en, bram_addr, m_en, m_addr);
        end
        for (int i = 0; i < N; i++)
            if (exp_vld[i] && rsp_ready[i]) begin
                m_have[i] = 0; m_busy[i] = 0; m_last[i] = m_data[i];
            end
        m_en = (g >= 0);
        if (g >= 0) begin
            m_addr = waddr[g]; m_busy[g] = 1; m_have[g] = 1;
            m_pend[g] = e + 1 + 4;
            m_data[g] = DW'(waddr[g]) + 32'd3;
            m_ptr = (g + 1) % N;
            if (!sticky[g]) want[g] = 0;
        end
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        clear_wants();
        req_valid = '0;
        rsp_ready = '1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_wants();
        req_valid = '0;
        rst = 1'b1;
        model_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_data, bram_en, bram_addr} !== '0) begin
            errors++; $display("FAIL reset_outputs: got rdy=%h vld=%h en=%b addr=%h expected all zero",
                               req_ready, rsp_valid, bram_en, bram_addr);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs_rdy !== '0 || obs_en !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got rdy=%h en=%b expected 0 0", obs_rdy, obs_en);
        end
    endtask

    task automatic test_single();
        do_reset();
        want[3] = 1; waddr[3] = 11'h005;
        step();
        checks++;
        if (obs_rdy !== 16'h0008) begin
            errors++; $display("FAIL single_grant: got %h expected 0008", obs_rdy);
        end
        steps(3);
        checks++;
        if (rsp_valid !== '0) begin
            errors++; $display("FAIL single_early: got %h expected 0000", rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 16'h0008 || rsp_data[3*DW +: DW] !== 32'h8) begin
            errors++; $display("FAIL single_rsp: got vld=%h data=%h expected 0008 00000008",
                               rsp_valid, rsp_data[3*DW +: DW]);
        end
        steps(3);
    endtask

    task automatic test_contention();
        int run, best;
        do_reset();
        for (int i = 0; i < N; i++) begin want[i] = 1; waddr[i] = AW'(i); end
        run = 0; best = 0;
        for (int c = 0; c < N + 6; c++) begin
            step();
            if (c < N) begin
                checks++;
                if (obs_rdy !== (16'h1 << c)) begin
                    errors++; $display("FAIL contention_order[%0d]: got %h expected %h", c, obs_rdy, 16'h1 << c);
                end
            end
            run = obs_en ? run + 1 : 0;
            if (run > best) best = run;
        end
        checks++;
        if (best !== N) begin
            errors++; $display("FAIL contention_en_run: got %0d expected %0d", best, N);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rsp_data[i*DW +: DW] !== DW'(i + 3)) begin
                errors++; $display("FAIL contention_data[%0d]: got %h expected %h", i, rsp_data[i*DW +: DW], i + 3);
            end
        end
    endtask

    task automatic test_wrap();
        want[14] = 1; waddr[14] = 11'h0E0;
        steps(7);
        want[15] = 1; waddr[15] = 11'h7FF;
        want[0]  = 1; waddr[0]  = 11'h000;
        step();
        checks++;
        if (obs_rdy !== 16'h8000) begin
            errors++; $display("FAIL wrap_first: got %h expected 8000", obs_rdy);
        end
        step();
        checks++;
        if (obs_rdy !== 16'h0001) begin
            errors++; $display("FAIL wrap_second: got %h expected 0001", obs_rdy);
        end
        steps(7);
        want[0] = 1; want[1] = 1; waddr[1] = 11'h111;
        step();
        checks++;
        if (obs_rdy !== 16'h0002) begin
            errors++; $display("FAIL wrap_ptr_after: got %h expected 0002", obs_rdy);
        end
        steps(8);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        bit seen;
        rsp_ready[2] = 1'b0;
        want[2] = 1; sticky[2] = 1; waddr[2] = 11'h222;
        want[4] = 1; waddr[4] = 11'h444;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            step();
            seen = rsp_valid[2];
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid[2] expected one within 12 cycles");
        end
        held = rsp_data[2*DW +: DW];
        for (int c = 0; c < 5; c++) begin
            step();
            checks += 2;
            if (obs_rdy[2] !== 1'b0) begin
                errors++; $display("FAIL bp_regrant[%0d]: got 1 expected 0", c);
            end
            if (rsp_data[2*DW +: DW] !== held || rsp_valid[2] !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got %h/%b expected %h/1", c, rsp_data[2*DW +: DW], rsp_valid[2], held);
            end
        end
        checks++;
        if (rsp_data[4*DW +: DW] !== 32'h447) begin
            errors++; $display("FAIL bp_core4: got %h expected 00000447", rsp_data[4*DW +: DW]);
        end
        rsp_ready[2] = 1'b1;
        step();
        step();
        checks++;
        if (obs_rdy !== 16'h0004) begin
            errors++; $display("FAIL bp_regrant_after: got %h expected 0004", obs_rdy);
        end
        sticky[2] = 0; want[2] = 0;
        steps(6);
    endtask

    task automatic test_reset_mid();
        want[0] = 1; waddr[0] = 11'h010;
        want[1] = 1; waddr[1] = 11'h011;
        steps(3);
        rst = 1'b1;
        model_reset();
        clear_wants();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (rsp_valid[1:0] !== 2'b00) begin
                errors++; $display("FAIL mid_reset_rsp[%0d]: got %b expected 00", c, rsp_valid[1:0]);
            end
        end
        want[5] = 1; waddr[5] = 11'h123;
        steps(5);
        checks++;
        if (rsp_valid !== 16'h0020 || rsp_data[5*DW +: DW] !== 32'h126) begin
            errors++; $display("FAIL mid_reset_after: got %h/%h expected 0020/00000126", rsp_valid, rsp_data[5*DW +: DW]);
        end
        steps(3);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && !m_busy[i] && $urandom_range(2) == 0) begin
                    want[i] = 1; waddr[i] = AW'($urandom);
                end
                rsp_ready[i] = ($urandom_range(9) < 7);
            end
            step();
        end
        clear_wants();
        rsp_ready = '1;
        steps(10);
    endtask

    initial begin
        model_reset();
        clear_wants();
        for (int i = 0; i < N; i++) waddr[i] = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
